// File: rtl/cnn_pkg.sv
// Types, widths and helpers shared by the conv channel block and its
// downstream accumulate/pool stage.
package cnn_pkg;

  localparam int CONV_W = 20;
  localparam int ACT_W  = 8;

  typedef enum logic [1:0] {
    S_ACC,
    S_POST,
    S_OUT
  } pool_state_t;

  typedef logic signed [1:0][1:0][CONV_W-1:0] conv_tile_t;

  // Clamp a non-negative value to the largest unsigned number of 'width' bits.
  function automatic logic [63:0] sat_u(input logic [63:0] value, input int unsigned width);
    logic [63:0] lim;
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value > lim) ? lim : value;
  endfunction

endpackage

// File: rtl/pool_post.sv
// Combinational post-processing of an accumulated 2x2 tile: max, bias, ReLU,
// right-shift requantization and unsigned saturation.
module pool_post
  import cnn_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = ACT_W
) (
  input  logic [1:0][1:0][ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0]    bias,
  input  logic [4:0]                 shift,
  output logic [OUT_W-1:0]           pool_out
);

  logic signed [ACC_W-1:0] m;
  logic signed [ACC_W:0]   s;
  logic [ACC_W:0]          r;
  logic [ACC_W:0]          q;

  always_comb begin
    m = $signed(acc[0][0]);
    for (int i = 1; i < 4; i++) begin
      if ($signed(acc[i/2][i%2]) > m) m = $signed(acc[i/2][i%2]);
    end
  end

  // Max before bias is exact: bias and ReLU are both monotone.
  assign s = {m[ACC_W-1], m} + {bias[ACC_W-1], bias};
  assign r = s[ACC_W] ? '0 : s;
  assign q = r >> shift;
  assign pool_out = OUT_W'(sat_u(64'(q), OUT_W));

endmodule

// File: rtl/chan_accum_pool.sv
// Accumulates one 2x2 tile over NUM_CHAN channels, then emits a single pooled,
// requantized unsigned activation over a valid/ready handshake.
module chan_accum_pool
  import cnn_pkg::*;
#(
  parameter int NUM_CHAN = 4,
  parameter int IN_W     = CONV_W,
  parameter int ACC_W    = 24,
  parameter int OUT_W    = ACT_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [1:0][1:0][IN_W-1:0]    conv_in,
  output logic [$clog2(NUM_CHAN)-1:0]         chan_idx,
  input  logic signed [ACC_W-1:0]             bias,
  input  logic [4:0]                          shift,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_W-1:0]                    pool_out
);

  localparam int CW = $clog2(NUM_CHAN);
  localparam logic [CW-1:0] LAST_CHAN = CW'(NUM_CHAN - 1);

  if (NUM_CHAN < 2) begin : g_chan_check
    $error("chan_accum_pool: NUM_CHAN must be at least 2");
  end
  if (ACC_W < IN_W + $clog2(NUM_CHAN)) begin : g_width_check
    $error("chan_accum_pool: ACC_W too narrow for NUM_CHAN accumulations");
  end

  pool_state_t               state;
  logic [1:0][1:0][ACC_W-1:0] acc;
  logic [OUT_W-1:0]          pool_d;

  assign in_ready = (state == S_ACC) && !rst;

  pool_post #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_post (
    .acc      (acc),
    .bias     (bias),
    .shift    (shift),
    .pool_out (pool_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      chan_idx  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      pool_out  <= '0;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            for (int r = 0; r < 2; r++) begin
              for (int c = 0; c < 2; c++) begin
                // Channel 0 reloads, so no separate clear is needed between tiles.
                if (chan_idx == '0)
                  acc[r][c] <= ACC_W'($signed(conv_in[r][c]));
                else
                  acc[r][c] <= acc[r][c] + ACC_W'($signed(conv_in[r][c]));
              end
            end
            if (chan_idx == LAST_CHAN) begin
              chan_idx <= '0;
              state    <= S_POST;
            end else begin
              chan_idx <= chan_idx + 1'b1;
            end
          end
        end
        S_POST: begin
          pool_out  <= pool_d;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: doc/chan_accum_pool.md
# chan_accum_pool

Downstream stage of the 2x2 convolution channel block: accepts one 2x2 tile of signed convolution partial sums per input channel. Accumulates the tile over `NUM_CHAN` channels, then adds a bias, applies ReLU, 2x2 max-pools, requantizes by right shift and saturates. Emits one unsigned 8-bit activation per tile over a valid/ready handshake. It feeds the next layer's image assembly.

## Interface

Parameters:

- `NUM_CHAN`, 4: input channels accumulated per output pixel; must be ≥ 2.
- `IN_W`, 20: width of each signed conv partial sum.
- `ACC_W`, 24: accumulator width. Elaboration fails unless `ACC_W >= IN_W + $clog2(NUM_CHAN)`.
- `OUT_W`, 8: unsigned output width.

Ports (one clock; reset is synchronous and active-high):

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `conv_in` holds a valid tile.
- `in_ready`  out  1  block accepts a tile this cycle.
- `conv_in`  in  signed `IN_W` x [1:0][1:0]  one channel's 2x2 partial sums.
- `chan_idx`  out  `$clog2(NUM_CHAN)`  index of the channel expected next; upstream uses it for kernel selection.
- `bias`  in  signed `ACC_W`  per-tile bias; must be stable from the first accepted beat of a tile until `out_valid`.
- `shift`  in  5  right-shift amount, 0..`ACC_W`; same stability rule as `bias`.
- `out_valid`  out  1  `pool_out` is valid.
- `out_ready`  in  1  consumer accepts `pool_out`.
- `pool_out`  out  `OUT_W`  unsigned pooled activation.

## Operation

- FSM states: `S_ACC`, `S_POST`, `S_OUT`.
- **S_ACC:**
  - `in_ready` = 1.
  - A beat is accepted on an edge with `in_valid && in_ready`.
  - If `chan_idx == 0`, `acc[r][c]` is loaded with the sign-extended `conv_in[r][c]`. Otherwise `conv_in[r][c]` is added to `acc[r][c]`.
  - `chan_idx` increments on each accepted beat.
  - On the beat accepted with `chan_idx == NUM_CHAN-1`: `chan_idx` wraps to 0 and the FSM goes to `S_POST`.
  - Cycles with `in_valid` low leave all state unchanged.
- **S_POST** (exactly one cycle; `in_ready` = 0):
  - m = max of the four `acc` entries, signed compare.
  - s = m + `bias`, computed at `ACC_W+1` bits.
  - r = 0 if s < 0, else s.
  - q = r >> `shift` (truncation, no rounding).
  - `pool_out` <= min(q, 2^`OUT_W`−1).
  - `out_valid` <= 1; go to `S_OUT`.
  - Max-before-bias is bit-exact to per-element bias, ReLU, then max, because bias and ReLU are monotone.
- **S_OUT** (`in_ready` = 0):
  - Hold `pool_out` and `out_valid` stable.
  - On an edge with `out_ready` high: `out_valid` <= 0, go to `S_ACC`.
- The accumulator cannot overflow, by the width rule on `ACC_W`.
- A `shift` ≥ `ACC_W` yields 0.
- **Reset:**
  - State `S_ACC`, `chan_idx` = 0, `acc` = 0, `out_valid` = 0, `pool_out` = 0.
  - `in_ready` is forced to 0 while `rst` is high.
  - Reset mid-accumulation or mid-output discards the partial tile or the pending result; the next accepted beat is channel 0.

## Timing

- **Latency:** the last channel beat is accepted at edge k; `pool_out`/`out_valid` are registered at edge k+1.
- **Throughput:** at best one tile per `NUM_CHAN`+2 cycles (`NUM_CHAN` accept cycles, 1 `S_POST`, ≥1 `S_OUT`). Input is never overlapped with output.
- `in_ready` depends only on state and `rst`. There is no combinational path from `in_valid` or `out_ready` to any output.
- `out_valid`, once high, stays high with `pool_out` unchanged until the `out_ready` handshake edge.
- `chan_idx` is registered and changes only on accepted beats, on tile wrap, or on reset.

## Structure

- Shared package `cnn_pkg` holds:
  - widths `CONV_W` = 20 and `ACT_W` = 8;
  - the state enum `pool_state_t`;
  - the function `sat_u(value, width)`.
- The tile type `conv_tile_t` (signed [1:0][1:0]) also lives in `cnn_pkg`, so that this block and the upstream conv block share it.
- One sub-module, `pool_post`: combinational max, bias, ReLU, shift and saturate, instantiated once; its result is registered in `S_POST`.
- The top level holds the FSM, `chan_idx`, the accumulator array and the output register.

## Test plan

- **Basic:** `NUM_CHAN`=4, four beats with all `conv_in` = 100, `bias` = 0, `shift` = 2 → `acc` = 400, `pool_out` = 100, `out_valid` exactly 1 edge after the 4th accept.
- **ReLU:** four beats of tile {−50, −10, −30, −5}, `bias` = 0 → `acc` max = −20, `pool_out` = 0.
- **Saturation:** `conv_in[0][0]` = 300000 with others 0, four beats, `shift` = 4 → q = 75000, `pool_out` = 255. No accumulator wrap (1,200,000 fits in 24 bits).
- **Negative bias and gaps:** max tile entry 40 per channel, `in_valid` toggled 1-0-1-0 …, `bias` = −100, `shift` = 1 → `pool_out` = 30; `chan_idx` advances only on accepts.
- **Backpressure:** `out_ready` held low 5 cycles after `out_valid` → `pool_out` stable, `in_ready` = 0, offered beats not consumed. Then `out_ready` = 1 → `out_valid` drops and the next beat is accepted as channel 0.
- **Reset mid-tile:** accept 2 beats of value 50, pulse `rst` 1 cycle, then 4 beats of all 1 with `bias` = 3, `shift` = 0 → `pool_out` = 7; `out_valid` = 0 and `chan_idx` = 0 right after reset.
